// File: rtl/tap_rec_if.sv
// Write port from the tape recorder into the tapdata RAM.
interface tap_rec_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] tap_address;
  logic [7:0]        tap_data;
  logic              tap_we;

  modport master (output tap_address, tap_data, tap_we);
  modport slave  (input  tap_address, tap_data, tap_we);
endinterface

// File: rtl/tap_rec.sv
// Tape recorder: turns the MIC square wave into TAP blocks in tapdata RAM.
// Half-periods are measured in ce ticks; pilot, sync and bit timing pick the
// phase, data bytes go out MSB first from base+2, and the little-endian block
// length is backfilled at base/base+1 once the block ends.
module tap_rec #(
  parameter int ADDR_W    = 17,
  parameter int PILOT_LO  = 1800,
  parameter int PILOT_HI  = 2600,
  parameter int PILOT_MIN = 256,
  parameter int SYNC_MAX  = 1000,
  parameter int BIT_THR   = 2400,
  parameter int TIMEOUT   = 14000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       arm,
  input  logic       mic_in,
  tap_rec_if.master  tap,
  output logic       busy,
  output logic       full,
  output logic [7:0] blocks
);
  localparam int              PC_W   = $clog2(PILOT_MIN + 1);
  localparam logic [15:0]     W_LO   = 16'(PILOT_LO);
  localparam logic [15:0]     W_HI   = 16'(PILOT_HI);
  localparam logic [15:0]     W_SYNC = 16'(SYNC_MAX);
  localparam logic [15:0]     W_TMO  = 16'(TIMEOUT);
  localparam logic [16:0]     W_THR  = 17'(BIT_THR);
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(PILOT_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_SYNC2, S_DATA, S_LEN_LO, S_LEN_HI
  } state_t;

  state_t state, state_n;

  logic              mic_q;
  logic [15:0]       cnt;
  logic [PC_W-1:0]   pcount;
  logic              half;
  logic [15:0]       w1;
  logic [7:0]        shreg;
  logic [2:0]        nbit;
  logic [ADDR_W-1:0] wptr, base, dptr;
  logic [15:0]       len;

  logic        mic_edge, tmo, w_pilot, w_short, pilot_ok;
  logic [16:0] sum;
  logic        bit_val, byte_done;
  logic [7:0]  byte_val;
  logic        pc_clr, pc_inc, data_init, data_edge, wr_lo, wr_hi;

  // cnt holds the width of the half-period just ended when an edge arrives
  assign mic_edge  = mic_in ^ mic_q;
  assign tmo       = cnt >= W_TMO;
  assign w_pilot   = (cnt >= W_LO) && (cnt <= W_HI);
  assign w_short   = cnt < W_SYNC;
  assign pilot_ok  = pcount >= PC_MAX;
  assign sum       = {1'b0, w1} + {1'b0, cnt};
  assign bit_val   = sum >= W_THR;
  assign byte_val  = {shreg[6:0], bit_val};
  assign byte_done = data_edge && half && (nbit == 3'd7);
  assign busy      = (state == S_SYNC2) || (state == S_DATA) ||
                     (state == S_LEN_LO) || (state == S_LEN_HI);

  // Edge detector and half-period tick counter (saturating, frozen when ce=0)
  always_ff @(posedge clock) begin
    if (reset) begin
      mic_q <= 1'b0;
      cnt   <= 16'd0;
    end else begin
      mic_q <= mic_in;
      if (mic_edge)                   cnt <= 16'd0;
      else if (ce && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and per-cycle action strobes
  always_comb begin
    state_n   = state;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    data_init = 1'b0;
    data_edge = 1'b0;
    wr_lo     = 1'b0;
    wr_hi     = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_n = S_PILOT;
          pc_clr  = 1'b1;
        end
      end
      S_PILOT: begin
        if (!arm) begin
          state_n = S_IDLE;
        end else if (mic_edge) begin
          if (w_pilot)                   pc_inc  = 1'b1;
          else if (w_short && pilot_ok)  state_n = S_SYNC2;
          else                           pc_clr  = 1'b1;
        end else if (tmo) begin
          pc_clr = 1'b1;
        end
      end
      S_SYNC2: begin
        if (!arm) begin
          state_n = S_IDLE;
        end else if (mic_edge && w_short) begin
          state_n   = S_DATA;
          data_init = 1'b1;
        end else if (mic_edge || tmo) begin
          state_n = S_PILOT;
          pc_clr  = 1'b1;
        end
      end
      S_DATA: begin
        // End of block wins over an edge landing in the same cycle
        if (tmo || !arm) begin
          if (len == 16'd0) begin
            state_n = arm ? S_PILOT : S_IDLE;
            pc_clr  = 1'b1;
          end else begin
            state_n = S_LEN_LO;
          end
        end else if (mic_edge) begin
          data_edge = 1'b1;
        end
      end
      S_LEN_LO: begin
        wr_lo   = 1'b1;
        state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        wr_hi   = 1'b1;
        state_n = arm ? S_PILOT : S_IDLE;
        pc_clr  = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pilot half-period counter, saturating at the sync-enable count
  always_ff @(posedge clock) begin
    if (reset)                            pcount <= '0;
    else if (pc_clr)                      pcount <= '0;
    else if (pc_inc && pcount != PC_MAX)  pcount <= pcount + PC_W'(1);
  end

  // Bit assembly: pair two half-periods, classify their sum, shift MSB first
  always_ff @(posedge clock) begin
    if (reset) begin
      half  <= 1'b0;
      w1    <= 16'd0;
      shreg <= 8'd0;
      nbit  <= 3'd0;
    end else if (data_init) begin
      half <= 1'b0;
      nbit <= 3'd0;
    end else if (data_edge) begin
      if (!half) begin
        w1   <= cnt;
        half <= 1'b1;
      end else begin
        shreg <= byte_val;
        half  <= 1'b0;
        nbit  <= nbit + 3'd1;
      end
    end
  end

  // Block pointers, RAM write port and block statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr            <= '0;
      base            <= '0;
      dptr            <= '0;
      len             <= 16'd0;
      full            <= 1'b0;
      blocks          <= 8'd0;
      tap.tap_we      <= 1'b0;
      tap.tap_address <= '0;
      tap.tap_data    <= 8'd0;
    end else begin
      tap.tap_we <= 1'b0;
      if (data_init) begin
        base <= wptr;
        dptr <= wptr + ADDR_W'(2);
        len  <= 16'd0;
      end
      // Last address is never used for data so dptr+1 cannot wrap
      if (byte_done) begin
        if (&dptr) begin
          full <= 1'b1;
        end else begin
          tap.tap_we      <= 1'b1;
          tap.tap_address <= dptr;
          tap.tap_data    <= byte_val;
          dptr            <= dptr + ADDR_W'(1);
          len             <= len + 16'd1;
        end
      end
      if (wr_lo) begin
        tap.tap_we      <= 1'b1;
        tap.tap_address <= base;
        tap.tap_data    <= len[7:0];
      end
      if (wr_hi) begin
        tap.tap_we      <= 1'b1;
        tap.tap_address <= base + ADDR_W'(1);
        tap.tap_data    <= len[15:8];
        wptr            <= dptr;
        blocks          <= blocks + 8'd1;
      end
    end
  end
endmodule
